// File: rtl/lsu_mem_stage_if.sv
// Data-memory port between the MEM-stage LSU (master) and the memory system (slave).
interface lsu_mem_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN/8-1:0] dmem_wstrb;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [XLEN-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV64 MEM-stage load/store unit: req/gnt/rvalid handshake on a 64-bit data port,
// store lane steering, load extraction and a REQ+WAIT timeout.
module lsu_mem_stage #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        read_type,
  input  logic [1:0]        write_type,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  lsu_mem_stage_if.master   dmem
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              store_q;
  logic [2:0]        rtype_q;
  logic [2:0]        off_q;

  logic [2:0]        off;
  logic              misalign_c;
  logic [7:0]        wstrb_c;
  logic [XLEN-1:0]   wdata_c;
  logic              start_c;
  logic              accept_c;
  logic [XLEN-1:0]   shifted_c;
  logic [XLEN-1:0]   load_c;
  logic              last_c;

  assign off = addr_i[2:0];

  // Alignment check and store lane steering for the access being offered.
  always_comb begin
    misalign_c = 1'b0;
    wstrb_c    = 8'h00;
    wdata_c    = '0;
    if (mem_write) begin
      case (write_type)
        2'd0: begin
          wstrb_c = 8'h01 << off;
          wdata_c = {8{wdata_i[7:0]}};
        end
        2'd1: begin
          misalign_c = off[0];
          wstrb_c    = 8'h03 << off;
          wdata_c    = {4{wdata_i[15:0]}};
        end
        2'd2: begin
          misalign_c = |off[1:0];
          wstrb_c    = 8'h0F << off;
          wdata_c    = {2{wdata_i[31:0]}};
        end
        default: begin
          misalign_c = |off;
          wstrb_c    = 8'hFF;
          wdata_c    = wdata_i;
        end
      endcase
    end else begin
      case (read_type)
        3'd1, 3'd5: misalign_c = off[0];
        3'd2, 3'd6: misalign_c = |off[1:0];
        3'd3:       misalign_c = |off;
        3'd7:       misalign_c = 1'b1;
        default:    misalign_c = 1'b0;
      endcase
    end
  end

  assign start_c  = valid_i & mem_read & (state == ST_IDLE);
  assign accept_c = start_c & ~misalign_c;
  assign stall_o  = (state == ST_REQ) || (state == ST_WAIT) || accept_c;
  assign last_c   = (cnt == CNT_W'(TIMEOUT - 1));

  // Load data alignment and extension from the latched type/offset.
  always_comb begin
    shifted_c = dmem.dmem_rdata >> {off_q, 3'b000};
    case (rtype_q)
      3'd0:    load_c = {{56{shifted_c[7]}},  shifted_c[7:0]};
      3'd1:    load_c = {{48{shifted_c[15]}}, shifted_c[15:0]};
      3'd2:    load_c = {{32{shifted_c[31]}}, shifted_c[31:0]};
      3'd3:    load_c = shifted_c;
      3'd4:    load_c = {56'b0, shifted_c[7:0]};
      3'd5:    load_c = {48'b0, shifted_c[15:0]};
      3'd6:    load_c = {32'b0, shifted_c[31:0]};
      default: load_c = '0;
    endcase
    if (store_q) load_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      store_q         <= 1'b0;
      rtype_q         <= 3'd0;
      off_q           <= 3'd0;
      done_o          <= 1'b0;
      rdata_o         <= '0;
      misalign_o      <= 1'b0;
      bus_err_o       <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_wstrb <= '0;
    end else begin
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            state           <= ST_REQ;
            cnt             <= '0;
            store_q         <= mem_write;
            rtype_q         <= read_type;
            off_q           <= off;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= mem_write;
            dmem.dmem_addr  <= {addr_i[XLEN-1:3], 3'b000};
            dmem.dmem_wdata <= wdata_c;
            dmem.dmem_wstrb <= wstrb_c;
          end else if (start_c) begin
            misalign_o <= 1'b1;
          end
        end
        ST_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (dmem.dmem_gnt && dmem.dmem_rvalid) begin
            state         <= ST_RESP;
            dmem.dmem_req <= 1'b0;
            done_o        <= 1'b1;
            rdata_o       <= load_c;
          end else if (last_c) begin
            state         <= ST_IDLE;
            dmem.dmem_req <= 1'b0;
            bus_err_o     <= 1'b1;
          end else if (dmem.dmem_gnt) begin
            state         <= ST_WAIT;
            dmem.dmem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (dmem.dmem_rvalid) begin
            state   <= ST_RESP;
            done_o  <= 1'b1;
            rdata_o <= load_c;
          end else if (last_c) begin
            state     <= ST_IDLE;
            bus_err_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: vector table of single accesses plus reset/ignore sequences.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  read_type = 3'd0;
  logic [1:0]  write_type = 2'd0;
  logic [63:0] addr_i = '0;
  logic [63:0] wdata_i = '0;
  logic        stall_o, done_o, misalign_o, bus_err_o;
  logic [63:0] rdata_o;

  lsu_mem_stage_if #(.XLEN(64)) dmem ();

  lsu_mem_stage #(.XLEN(64), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .read_type  (read_type),
    .write_type (write_type),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .rdata_o    (rdata_o),
    .misalign_o (misalign_o),
    .bus_err_o  (bus_err_o),
    .dmem       (dmem.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  rt;
    logic [1:0]  wt;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          gnt_c;
    int          rv_c;
    logic        mis;
    logic [63:0] e_addr;
    logic [7:0]  e_wstrb;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
    int          e_done;
    int          e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [2:0] rt, input logic [1:0] wt,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] rdata, input int gnt_c, input int rv_c,
                              input logic mis, input logic [63:0] e_addr, input logic [7:0] e_wstrb,
                              input logic [63:0] e_wdata, input logic [63:0] e_rdata,
                              input int e_done, input int e_err);
    vec_t v;
    v.wr = wr; v.rt = rt; v.wt = wt; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gnt_c = gnt_c; v.rv_c = rv_c; v.mis = mis; v.e_addr = e_addr; v.e_wstrb = e_wstrb;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_done = e_done; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Apply one access at cycle 0, then run a fixed 12-cycle window driving gnt/rvalid.
  task automatic run_vec(input vec_t v, input int id);
    int          done_c, mis_c, err_c, stall_n, exp_stall;
    logic [63:0] rd;
    logic        req1, we1;
    logic [63:0] addr1, wdata1;
    logic [7:0]  wstrb1;
    done_c = -1; mis_c = -1; err_c = -1; stall_n = 0; rd = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; wstrb1 = '0;
    valid_i = 1'b1; mem_read = 1'b1; mem_write = v.wr; read_type = v.rt; write_type = v.wt;
    addr_i = v.addr; wdata_i = v.wdata;
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = v.rdata;
    @(negedge clk);
    if (stall_o) stall_n++;
    @(posedge clk); #1;
    valid_i = 1'b0; addr_i = ~v.addr; wdata_i = ~v.wdata;
    read_type = ~v.rt; write_type = ~v.wt;
    for (int c = 1; c <= 12; c++) begin
      dmem.dmem_gnt    = (c == v.gnt_c);
      dmem.dmem_rvalid = (c == v.rv_c);
      @(negedge clk);
      if (stall_o) stall_n++;
      if (done_o && done_c < 0) begin done_c = c; rd = rdata_o; end
      if (misalign_o && mis_c < 0) mis_c = c;
      if (bus_err_o && err_c < 0) err_c = c;
      if (c == 1) begin
        req1 = dmem.dmem_req; we1 = dmem.dmem_we; addr1 = dmem.dmem_addr;
        wdata1 = dmem.dmem_wdata; wstrb1 = dmem.dmem_wstrb;
      end
      @(posedge clk); #1;
    end
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0;
    exp_stall = v.mis ? 0 : ((v.e_done >= 0) ? v.e_done : v.e_err);
    chk($sformatf("v%0d_req", id), 64'(req1), 64'(!v.mis));
    chk($sformatf("v%0d_mis_cyc", id), 64'(mis_c), 64'(v.mis ? 1 : -1));
    chk($sformatf("v%0d_done_cyc", id), 64'(done_c), 64'(v.e_done));
    chk($sformatf("v%0d_err_cyc", id), 64'(err_c), 64'(v.e_err));
    chk($sformatf("v%0d_stall_cycles", id), 64'(stall_n), 64'(exp_stall));
    if (!v.mis) begin
      chk($sformatf("v%0d_we", id), 64'(we1), 64'(v.wr));
      chk($sformatf("v%0d_addr", id), addr1, v.e_addr);
      chk($sformatf("v%0d_wstrb", id), 64'(wstrb1), 64'(v.e_wstrb));
      chk($sformatf("v%0d_wdata", id), wdata1, v.e_wdata);
    end
    if (v.e_done >= 0) chk($sformatf("v%0d_rdata", id), rd, v.e_rdata);
  endtask

  initial begin
    int n_done, n_stall, n_req, n_mis;
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;

    // wr rt wt addr wdata rdata gnt rv mis e_addr e_wstrb e_wdata e_rdata e_done e_err
    vecs.push_back(mk(1, 0, 3, 64'h1000, 64'h1122334455667788, '1, 1, 3, 0,
                      64'h1000, 8'hFF, 64'h1122334455667788, 64'h0, 4, -1));
    vecs.push_back(mk(1, 0, 0, 64'h1005, 64'hAB, '1, 1, 2, 0,
                      64'h1000, 8'h20, 64'hABABABABABABABAB, 64'h0, 3, -1));
    vecs.push_back(mk(1, 0, 2, 64'h1004, 64'hCAFEBABE, '1, 2, 4, 0,
                      64'h1000, 8'hF0, 64'hCAFEBABECAFEBABE, 64'h0, 5, -1));
    vecs.push_back(mk(1, 0, 1, 64'h100A, 64'h1234, '1, 1, 2, 0,
                      64'h1008, 8'h0C, 64'h1234123412341234, 64'h0, 3, -1));
    vecs.push_back(mk(0, 0, 0, 64'h2003, 64'h0, 64'h0000000080000000, 1, 3, 0,
                      64'h2000, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80, 4, -1));
    vecs.push_back(mk(0, 4, 0, 64'h2003, 64'h0, 64'h0000000080000000, 1, 3, 0,
                      64'h2000, 8'h00, 64'h0, 64'h0000000000000080, 4, -1));
    vecs.push_back(mk(0, 6, 0, 64'h2004, 64'h0, 64'hDEADBEEF00000000, 1, 3, 0,
                      64'h2000, 8'h00, 64'h0, 64'h00000000DEADBEEF, 4, -1));
    vecs.push_back(mk(0, 2, 0, 64'h2004, 64'h0, 64'hDEADBEEF00000000, 1, 1, 0,
                      64'h2000, 8'h00, 64'h0, 64'hFFFFFFFFDEADBEEF, 2, -1));
    vecs.push_back(mk(0, 1, 0, 64'h3006, 64'h0, 64'h8001000000000000, 1, 2, 0,
                      64'h3000, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8001, 3, -1));
    vecs.push_back(mk(0, 5, 0, 64'h3006, 64'h0, 64'h8001000000000000, 1, 2, 0,
                      64'h3000, 8'h00, 64'h0, 64'h0000000000008001, 3, -1));
    vecs.push_back(mk(0, 3, 0, 64'h3000, 64'h0, 64'h0123456789ABCDEF, 1, 2, 0,
                      64'h3000, 8'h00, 64'h0, 64'h0123456789ABCDEF, 3, -1));
    vecs.push_back(mk(0, 1, 0, 64'h3001, 64'h0, '0, -1, -1, 1, '0, 8'h00, '0, '0, -1, -1));
    vecs.push_back(mk(0, 3, 0, 64'h3004, 64'h0, '0, -1, -1, 1, '0, 8'h00, '0, '0, -1, -1));
    vecs.push_back(mk(0, 7, 0, 64'h3000, 64'h0, '0, -1, -1, 1, '0, 8'h00, '0, '0, -1, -1));
    vecs.push_back(mk(1, 0, 2, 64'h1002, 64'h5, '0, -1, -1, 1, '0, 8'h00, '0, '0, -1, -1));
    vecs.push_back(mk(0, 2, 0, 64'h4000, 64'h0, '0, -1, -1, 0,
                      64'h4000, 8'h00, 64'h0, 64'h0, -1, 5));
    vecs.push_back(mk(0, 2, 0, 64'h4000, 64'h0, '0, 2, -1, 0,
                      64'h4000, 8'h00, 64'h0, 64'h0, -1, 5));

    // Reset state
    #3;
    chk("rst_stall", 64'(stall_o), 64'h0);
    chk("rst_done", 64'(done_o), 64'h0);
    chk("rst_req", 64'(dmem.dmem_req), 64'h0);
    chk("rst_addr", dmem.dmem_addr, 64'h0);
    chk("rst_rdata", rdata_o, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // valid_i without mem_read is ignored, even with a misaligned address
    valid_i = 1'b1; mem_read = 1'b0; mem_write = 1'b1; write_type = 2'd3; addr_i = 64'h1001;
    @(negedge clk);
    chk("ign_stall", 64'(stall_o), 64'h0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk("ign_req", 64'(dmem.dmem_req), 64'h0);
    chk("ign_mis", 64'(misalign_o), 64'h0);
    @(posedge clk); #1;

    // Reset asserted while waiting for the response
    valid_i = 1'b1; mem_read = 1'b1; mem_write = 1'b0; read_type = 3'd3; addr_i = 64'h5000;
    @(posedge clk); #1;
    valid_i = 1'b0; dmem.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem.dmem_gnt = 1'b0;
    #2; rst_n = 1'b0; #1;
    chk("wrst_stall", 64'(stall_o), 64'h0);
    chk("wrst_req", 64'(dmem.dmem_req), 64'h0);
    chk("wrst_addr", dmem.dmem_addr, 64'h0);
    chk("wrst_done", 64'(done_o), 64'h0);
    chk("wrst_err", 64'(bus_err_o), 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_done = 0; n_stall = 0; n_req = 0; n_mis = 0;
    for (int c = 0; c < 4; c++) begin
      dmem.dmem_rvalid = (c == 0);
      dmem.dmem_rdata = 64'hFFFFFFFFFFFFFFFF;
      @(negedge clk);
      if (done_o || bus_err_o) n_done++;
      if (stall_o) n_stall++;
      if (dmem.dmem_req) n_req++;
      if (misalign_o) n_mis++;
      @(posedge clk); #1;
    end
    dmem.dmem_rvalid = 1'b0;
    chk("stale_done", 64'(n_done), 64'h0);
    chk("stale_stall", 64'(n_stall), 64'h0);
    chk("stale_req", 64'(n_req), 64'h0);
    chk("stale_mis", 64'(n_mis), 64'h0);
    run_vec(mk(0, 3, 0, 64'h5000, 64'h0, 64'hA5A5000012345678, 1, 2, 0,
               64'h5000, 8'h00, 64'h0, 64'hA5A5000012345678, 3, -1), 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit for the MEM stage of the RV64IM core.
- Consumes the decoder's memory controls (mem_read, mem_write, read_type, write_type), the EXU effective address and the store operand.
- Runs a request/grant/response handshake on the 64-bit data-memory port and returns aligned, extended load data to WB.
- Holds stall_o high while an access is outstanding.

Parameters:
- XLEN, 64, data/address width; only 64 is supported.
- TIMEOUT, 255, maximum cycles in REQ plus WAIT before bus error; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  MEM stage holds a valid instruction (single-cycle start pulse when idle)
- mem_read  in  1  access request; decoder asserts it for loads and stores
- mem_write  in  1  store when 1; load when mem_read=1 and mem_write=0
- read_type  in  3  funct3: 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU, 7 illegal
- write_type  in  2  0 SB, 1 SH, 2 SW, 3 SD
- addr_i  in  64  effective byte address
- wdata_i  in  64  store operand, data in low bits
- stall_o  out  1  pipeline hold
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  64  extended load data; valid when done_o=1
- misalign_o  out  1  one-cycle pulse; access rejected
- bus_err_o  out  1  one-cycle pulse; timeout
- dmem_req  out  1  bus request
- dmem_we  out  1  write enable
- dmem_addr  out  64  addr_i with [2:0] forced to 0
- dmem_wdata  out  64  store data replicated to its byte lanes
- dmem_wstrb  out  8  byte strobes; 0 for reads
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  response valid (reads and write acknowledgements)
- dmem_rdata  in  64  read data, aligned doubleword

Behaviour:
Reset:
- All outputs 0, FSM in IDLE, timeout counter 0.
- Asserting rst_n low mid-access aborts the access immediately. No done_o or bus_err_o is produced, and any later rvalid is ignored.

FSM states: IDLE, REQ, WAIT, RESP.

IDLE:
- valid_i & mem_read with an aligned access: latch type, byte offset addr_i[2:0] and bus fields; go to REQ; stall_o=1 from the next cycle.
- Misaligned access: pulse misalign_o, no bus activity, stay in IDLE. Misaligned means halfword with addr[0]≠0, word with addr[1:0]≠0, or doubleword with addr[2:0]≠0.
- Load with read_type=7: treated the same as misaligned.
- valid_i with mem_read=0: ignored.

REQ:
- dmem_req=1, all bus fields stable.
- gnt=1 goes to WAIT. If gnt and rvalid arrive in the same cycle, go straight to RESP.

WAIT:
- dmem_req=0.
- rvalid=1 goes to RESP and captures rdata.

RESP:
- One cycle: done_o=1, stall_o=0, then IDLE.
- The next valid_i is sampled in the IDLE cycle after RESP; there is no back-to-back acceptance in RESP.

Stall:
- stall_o=1 in REQ and WAIT. It is also 1 in IDLE on the start cycle, combinationally from valid_i & mem_read when the access is aligned.

Store lane rules, with off = addr[2:0]:
- SB: wstrb = 1<<off; wdata = wdata_i[7:0] replicated ×8.
- SH: wstrb = 0x3<<off; low halfword replicated ×4.
- SW: wstrb = 0xF<<off; low word replicated ×2.
- SD: wstrb = 0xFF; wdata = wdata_i.

Load extraction, from data shifted right by off×8:
- LB/LH/LW sign-extend bit 7/15/31.
- LBU/LHU/LWU zero-extend.
- LD passes the full doubleword.
- For stores, rdata_o=0.

Timeout:
- Counter increments each cycle in REQ/WAIT and clears on entry to REQ.
- When it reaches TIMEOUT: bus_err_o pulse, done_o=0, go to IDLE, stall_o drops.

Other rules:
- rvalid while in IDLE or REQ (without gnt) is ignored.
- Inputs other than valid_i are sampled only at acceptance.

Test Plan:
- SD addr 0x1000 data 0x1122334455667788; gnt on cycle 1, rvalid on cycle 3 -> wstrb=0xFF, dmem_addr=0x1000, done_o on cycle 4, stall_o high for cycles 0-3.
- SB addr 0x1005 data 0xAB -> wstrb=0x20, wdata=0xABABABABABABABAB. SW addr 0x1004 -> wstrb=0xF0.
- LB addr 0x2003, rdata=0x00000000_80000000 -> rdata_o=0xFFFFFFFFFFFFFF80. LBU at the same address -> 0x80. LWU addr 0x2004, rdata=0xDEADBEEF_00000000 -> 0x00000000DEADBEEF.
- LH addr 0x3001 and LD addr 0x3004 -> misalign_o pulse, dmem_req stays 0, no done_o. read_type=7 -> misalign_o pulse.
- gnt and rvalid in the same cycle on LW -> RESP next cycle, total stall 2 cycles. gnt never asserted with TIMEOUT=4 -> bus_err_o after 4 cycles, FSM idle.
- Reset asserted while in WAIT -> all outputs 0 immediately. A stale rvalid after release is ignored, and a fresh load completes correctly.
